// File: rtl/load_store_unit.sv
// load_store_unit
// Bridges the multicycle core datapath to the unified instruction/data memory
// port. It accepts one load or store per request and drives a valid/ready bus
// with a word-aligned address, byte strobes and lane-replicated write data. It
// returns a sign- or zero-extended load result together with completion and
// fault status, so the core tolerates variable-latency memory.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   start                request strobe from the control FSM (sampled in IDLE)
//   we, funct3           store/load select and RISC-V width/sign field
//   addr, wdata          byte address and store data (rs2)
//   busy, done           not-idle indicator and one-cycle completion pulse
//   rdata                extended load result, held until the next done
//   misaligned, fault    status flags, valid together with done
//   mem_valid, mem_we    bus request and write enable
//   mem_addr             word-aligned bus address
//   mem_wstrb, mem_wdata byte-lane strobes and replicated store data
//   mem_ready, mem_rdata bus acknowledge and full read word

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        fault,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Wide enough to hold TIMEOUT_CYCLES itself, since the counter reaches it.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           we_q;
    logic [2:0]     funct3_q;
    logic [31:0]    addr_q;
    logic [CW-1:0]  wait_cnt;

    logic           req_legal;
    logic           req_misaligned;
    logic           req_go;
    logic [3:0]     wstrb_d;
    logic [31:0]    wdata_d;
    logic [31:0]    load_ext;
    logic [7:0]     load_byte;
    logic [15:0]    load_half;
    logic           timeout_hit;

    // Classify the incoming request. The legal funct3 set differs between loads
    // and stores. Alignment depends only on the access size in funct3[1:0].
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (we) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                default:                req_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b01:   req_misaligned = addr[0];
            2'b10:   req_misaligned = (addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    // Only a legal and naturally aligned request reaches the bus.
    assign req_go = req_legal && !req_misaligned;

    // Build the byte strobes and replicated store data from the live inputs, so
    // they can be registered once at acceptance and held steady during REQ.
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = wdata;
        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << addr[1:0];
                    wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb_d = 4'b1111;
                    wdata_d = wdata;
                end
            endcase
        end
    end

    // Select the addressed byte or halfword out of the returned word, then
    // extend it according to the latched funct3.
    assign load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign load_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0000, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // The counter value before this cycle's increment. Hitting the limit means
    // the current REQ cycle is the last one allowed.
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A ready in the last allowed cycle takes priority over
    // the timeout. start is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = req_go ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_ready || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latches, status flags, the result register and the registered
    // bus fields. Flags and the counter are cleared only when a new request is
    // accepted, so they stay readable during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0000_0000;
            wait_cnt   <= '0;
            rdata      <= 32'h0000_0000;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        we_q       <= we;
                        funct3_q   <= funct3;
                        addr_q     <= addr;
                        wait_cnt   <= '0;
                        fault      <= !req_legal;
                        misaligned <= req_legal && req_misaligned;
                        mem_we     <= we;
                        mem_wstrb  <= wstrb_d;
                        mem_wdata  <= wdata_d;
                        if (!req_go) begin
                            rdata <= 32'h0000_0000;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        rdata <= we_q ? 32'h0000_0000 : load_ext;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            fault <= 1'b1;
                            rdata <= 32'h0000_0000;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_valid = (state == REQ);
    assign mem_addr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit with TIMEOUT_CYCLES = 4. applyStimulus
// issues one request and pushes its expected response into a queue. A
// responder models a memory with a programmable number of wait cycles. A
// monitor pops the queue whenever done is seen, then compares the result,
// flags, latency, bus fields and the number of mem_valid cycles.

module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        fault;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .fault      (fault),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          chk_rdata;
        logic        mis;
        logic        flt;
        int          lat;
        int          vcyc;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic        mwe;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;
    int push_count = 0;

    // Memory responder settings, written by the stimulus tasks.
    int wait_cycles = 0;
    bit ready_never = 1'b0;
    int req_idx     = 0;

    // Monitor state.
    logic        prev_busy  = 1'b0;
    int          mon_lat    = 0;
    int          mon_vcyc   = 0;
    bit          mon_seen   = 1'b0;
    bit          mon_unstab = 1'b0;
    logic [31:0] cap_addr;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;
    logic        cap_we;
    exp_t        mon_e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Memory model: mem_ready rises after wait_cycles REQ cycles, or never.
    always @(negedge clk) begin
        if (mem_valid) begin
            req_idx++;
            mem_ready = !ready_never && (req_idx > wait_cycles);
        end else begin
            req_idx   = 0;
            mem_ready = 1'b0;
        end
    end

    // Monitor: measure latency from acceptance, capture and hold-check the bus
    // fields, and score each done against the oldest expected entry.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            mon_lat    = 1;
            mon_vcyc   = 0;
            mon_seen   = 1'b0;
            mon_unstab = 1'b0;
        end else begin
            mon_lat++;
        end
        if (mem_valid) begin
            mon_vcyc++;
            if (!mon_seen) begin
                mon_seen  = 1'b1;
                cap_addr  = mem_addr;
                cap_strb  = mem_wstrb;
                cap_wdata = mem_wdata;
                cap_we    = mem_we;
            end else if (cap_addr !== mem_addr || cap_strb !== mem_wstrb ||
                         cap_wdata !== mem_wdata || cap_we !== mem_we) begin
                mon_unstab = 1'b1;
            end
        end
        if (done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got a done, expected none pending");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk_rdata)
                    checkOutput($sformatf("t%0d_rdata", mon_e.id), rdata, mon_e.rdata);
                checkOutput($sformatf("t%0d_misaligned", mon_e.id), misaligned, mon_e.mis);
                checkOutput($sformatf("t%0d_fault", mon_e.id), fault, mon_e.flt);
                checkOutput($sformatf("t%0d_latency", mon_e.id), mon_lat, mon_e.lat);
                checkOutput($sformatf("t%0d_valid_cycles", mon_e.id), mon_vcyc, mon_e.vcyc);
                if (mon_e.vcyc > 0) begin
                    checkOutput($sformatf("t%0d_mem_addr", mon_e.id), cap_addr, mon_e.maddr);
                    checkOutput($sformatf("t%0d_mem_wstrb", mon_e.id), cap_strb, mon_e.strb);
                    checkOutput($sformatf("t%0d_mem_we", mon_e.id), cap_we, mon_e.mwe);
                    if (mon_e.mwe)
                        checkOutput($sformatf("t%0d_mem_wdata", mon_e.id), cap_wdata, mon_e.mwdata);
                    checkOutput($sformatf("t%0d_bus_stable", mon_e.id), mon_unstab, 0);
                end
            end
        end
        prev_busy = busy;
    end

    // Issue one request from the IDLE cycle, optionally poke start again while
    // busy, wait for done, then return in the cycle after done.
    task automatic applyStimulus(
        input int id, input logic w, input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] wd, input logic [31:0] rd, input int waits, input bit never,
        input logic [31:0] e_rdata, input bit e_chk, input logic e_mis, input logic e_flt,
        input int e_lat, input int e_vcyc, input logic [31:0] e_maddr,
        input logic [3:0] e_strb, input logic [31:0] e_mwdata, input bit poke);
        exp_t e;
        bit got;
        e.id = id;         e.rdata = e_rdata; e.chk_rdata = e_chk;
        e.mis = e_mis;     e.flt = e_flt;     e.lat = e_lat;
        e.vcyc = e_vcyc;   e.maddr = e_maddr; e.strb = e_strb;
        e.mwdata = e_mwdata; e.mwe = w;
        exp_q.push_back(e);
        push_count++;
        mem_rdata   = rd;
        wait_cycles = waits;
        ready_never = never;
        we     = w;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            start = 1'b1;
            we    = 1'b1;
            addr  = 32'h0000_0604;
            @(negedge clk);
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL t%0d_done_wait: got no done in 40 cycles, expected done", id);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        we        = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_wstrb", mem_wstrb, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_misaligned", misaligned, 0);
        checkOutput("rst_fault", fault, 0);
        reset = 1'b0;
        @(negedge clk);

        //            id we f3      addr          wdata         mem_rdata     wt nv exp_rdata    chk mis flt lat vc maddr         strb     mwdata        poke
        applyStimulus(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        0);
        applyStimulus(2, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF7F01, 0, 0, 32'hFFFFFF80, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        0);
        applyStimulus(3, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF7F01, 0, 0, 32'h00000080, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        0);
        applyStimulus(4, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF7F01, 0, 0, 32'hFFFF80FF, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        0);
        applyStimulus(5, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF7F01, 0, 0, 32'h00007F01, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        0);
        applyStimulus(6, 1, 3'b000, 32'h0000_0201, 32'h12345678, 32'hFFFFFFFF, 0, 0, 32'h00000000, 1, 0, 0, 2, 1, 32'h0000_0200, 4'b0010, 32'h78787878, 0);
        applyStimulus(7, 1, 3'b001, 32'h0000_0202, 32'h12345678, 32'hFFFFFFFF, 0, 0, 32'h00000000, 1, 0, 0, 2, 1, 32'h0000_0200, 4'b1100, 32'h56785678, 0);
        applyStimulus(8, 1, 3'b010, 32'h0000_0204, 32'h12345678, 32'hFFFFFFFF, 0, 0, 32'h00000000, 1, 0, 0, 2, 1, 32'h0000_0204, 4'b1111, 32'h12345678, 0);
        // Three wait cycles: ready lands in the cycle the counter hits the limit.
        applyStimulus(9, 0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFEF00D, 3, 0, 32'hCAFEF00D, 1, 0, 0, 5, 4, 32'h0000_0300, 4'b0000, 32'h0,        0);
        // No ready at all: four REQ cycles, then a fault.
        applyStimulus(10, 0, 3'b010, 32'h0000_0400, 32'h0,       32'h55555555, 0, 1, 32'h00000000, 1, 0, 1, 5, 4, 32'h0000_0400, 4'b0000, 32'h0,        0);
        applyStimulus(11, 0, 3'b010, 32'h0000_0102, 32'h0,       32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,        0);
        applyStimulus(12, 0, 3'b011, 32'h0000_0100, 32'h0,       32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,         4'b0000, 32'h0,        0);
        applyStimulus(13, 1, 3'b100, 32'h0000_0101, 32'h0,       32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,         4'b0000, 32'h0,        0);
        applyStimulus(14, 1, 3'b001, 32'h0000_0203, 32'h0,       32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,        0);
        applyStimulus(15, 0, 3'b000, 32'h0000_0101, 32'h0,       32'h0000A500, 2, 0, 32'hFFFFFFA5, 1, 0, 0, 4, 3, 32'h0000_0100, 4'b0000, 32'h0,        0);

        // Reset in the middle of REQ drops the request immediately.
        wait_cycles = 0;
        ready_never = 1'b1;
        we     = 1'b0;
        funct3 = 3'b010;
        addr   = 32'h0000_0700;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rmid_valid_before", mem_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rmid_valid_after", mem_valid, 0);
        checkOutput("rmid_busy_after", busy, 0);
        checkOutput("rmid_done_after", done, 0);
        checkOutput("rmid_rdata_after", rdata, 0);
        @(negedge clk);

        // start pulsed during REQ is ignored; only one done is expected.
        applyStimulus(16, 0, 3'b010, 32'h0000_0500, 32'h0,       32'h11112222, 3, 0, 32'h11112222, 1, 0, 0, 5, 4, 32'h0000_0500, 4'b0000, 32'h0,        1);
        // Issued in the cycle right after the previous done.
        applyStimulus(17, 1, 3'b000, 32'h0000_0003, 32'h000000AB, 32'h0,       0, 0, 32'h00000000, 1, 0, 0, 2, 1, 32'h0000_0000, 4'b1000, 32'hABABABAB, 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("done_count", done_count, push_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
